fc_weight_stream: RTL and testbench

FC_WEIGHT_STREAM -- requirements
Module: fc_weight_stream

---
 rtl/fc_weight_stream_if.sv | 30 +++
 rtl/fc_weight_stream.sv | 88 ++++++++
 tb/tb_fc_weight_stream.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fc_weight_stream_if.sv
// fc_weight_stream_if: storage write port, run control and entry stream of fc_weight_stream
interface fc_weight_stream_if #(
  parameter int BIT_WIDTH = 16,
  parameter int DEPTH     = 10,
  parameter int CHANNELS  = 5
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(CHANNELS + 1);
  logic                          wr_en;
  logic [SW-1:0]                 wr_sel;
  logic [AW-1:0]                 wr_addr;
  logic [BIT_WIDTH-1:0]          wr_data;
  logic                          start;
  logic [AW:0]                   length;
  logic                          ready;
  logic                          busy;
  logic                          valid;
  logic                          last;
  logic                          done;
  logic [BIT_WIDTH-1:0]          bias_out;
  logic [CHANNELS*BIT_WIDTH-1:0] data_out;
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, length, ready,
    input  busy, valid, last, done, bias_out, data_out
  );
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, length, ready,
    output busy, valid, last, done, bias_out, data_out
  );
endinterface

// File: rtl/fc_weight_stream.sv
// fc_weight_stream: per-neuron weight arrays plus bias, streamed one entry per handshake
module fc_weight_stream #(
  parameter int BIT_WIDTH = 16,
  parameter int DEPTH     = 10,
  parameter int CHANNELS  = 5
) (
  input logic           clk,
  input logic           rst,
  fc_weight_stream_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(CHANNELS + 1);
  localparam logic [AW:0]   DL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] CL = SW'(CHANNELS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                        state;
  logic [BIT_WIDTH-1:0]          mem [CHANNELS][DEPTH];
  logic [BIT_WIDTH-1:0]          bias_reg;
  logic [AW-1:0]                 idx;
  logic [AW-1:0]                 nxt_idx;
  logic [AW:0]                   len;
  logic [CHANNELS*BIT_WIDTH-1:0] rd_data;
  logic [SW-1:0]                 wr_ch;
  logic                          accept;
  logic                          step;
  assign accept  = state == IDLE && bus.start && bus.length != '0 && bus.length <= DL;
  assign step    = state == RUN && bus.valid && bus.ready;
  assign nxt_idx = state == IDLE ? '0 : idx + AW'(1);
  assign wr_ch   = bus.wr_sel - SW'(1);
  // storage is deliberately outside the reset domain so contents survive a reset
  always_ff @(posedge clk) begin
    if (bus.wr_en && bus.wr_sel == '0)
      bias_reg <= bus.wr_data;
    if (bus.wr_en && bus.wr_sel != '0 && bus.wr_sel <= CL && {1'b0, bus.wr_addr} < DL)
      mem[wr_ch][bus.wr_addr] <= bus.wr_data;
  end
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < CHANNELS; k++)
      rd_data[k*BIT_WIDTH +: BIT_WIDTH] = mem[k][nxt_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      len          <= '0;
      bus.busy     <= 1'b0;
      bus.valid    <= 1'b0;
      bus.last     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bias_out <= '0;
      bus.data_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state        <= RUN;
          idx          <= '0;
          len          <= bus.length;
          bus.busy     <= 1'b1;
          bus.valid    <= 1'b1;
          bus.last     <= bus.length == (AW+1)'(1);
          bus.bias_out <= bias_reg;
          bus.data_out <= rd_data;
        end
        RUN: if (step) begin
          if (bus.last) begin
            state        <= DONE;
            bus.valid    <= 1'b0;
            bus.last     <= 1'b0;
            bus.done     <= 1'b1;
            bus.bias_out <= '0;
            bus.data_out <= '0;
          end else begin
            idx          <= nxt_idx;
            bus.data_out <= rd_data;
            bus.last     <= {1'b0, nxt_idx} + (AW+1)'(1) == len;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_weight_stream.sv
// tb_fc_weight_stream: scoreboard bench with a storage model snapshotted at each accepted start
module tb_fc_weight_stream;
  localparam int BW = 16, D = 10, CH = 5;
  typedef struct {
    logic [CH*BW-1:0] data;
    logic [BW-1:0]    bias;
    logic             last;
    int               idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fc_weight_stream_if #(.BIT_WIDTH(BW), .DEPTH(D), .CHANNELS(CH)) bus ();
  fc_weight_stream #(.BIT_WIDTH(BW), .DEPTH(D), .CHANNELS(CH)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t             sb_q[$];
  logic [BW-1:0]    m_mem [CH][D];
  logic [BW-1:0]    m_bias;
  int               cmp_n = 0, err_n = 0, hs_n = 0;
  bit               rand_ready = 0, ready_force = 1;
  bit               pv = 0, pr = 0, pl = 0, exp_done = 0;
  logic [CH*BW-1:0] pd;
  logic [BW-1:0]    pb;
  function automatic void check(string name, logic [CH*BW-1:0] act, logic [CH*BW-1:0] req);
    cmp_n++;
    if (act !== req) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction
  function automatic void model_write(int sel, int addr, logic [BW-1:0] data);
    if (sel == 0) m_bias = data;
    else if (sel <= CH && addr < D) m_mem[sel-1][addr] = data;
  endfunction
  function automatic void push_run(int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < CH; k++) e.data[k*BW +: BW] = m_mem[k][i];
      e.bias = m_bias;
      e.last = (i == len - 1);
      e.idx  = i;
      sb_q.push_back(e);
    end
  endfunction
  task automatic set_write(int sel, int addr, logic [BW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 3'(sel);
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    model_write(sel, addr, data);
  endtask
  task automatic drive_write(int sel, int addr, logic [BW-1:0] data);
    set_write(sel, addr, data);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask
  // inj: 0 none, 1 mid-run writes, 2 stall on entry 1, 3 start in RUN/DONE, 4 reset on entry 2
  task automatic run(input int len, input int inj, output int n);
    int hs0;
    bit aborted;
    aborted = 0;
    push_run(len);
    hs0 = hs_n;
    bus.start  = 1'b1;
    bus.length = 5'(len);
    @(posedge clk); #1;
    n = 1;
    bus.start = 1'b0;
    check("start_latency", bus.valid, 1);
    while (!bus.done && n < 300 && !aborted) begin
      if (inj == 1 && n == 1) set_write(6, 0, 16'hBEEF);
      if (inj == 1 && n == 2) begin
        set_write(2, 3, 16'd123);
        foreach (sb_q[j]) if (sb_q[j].idx == 3) sb_q[j].data[BW +: BW] = 16'd123;
      end
      if (inj == 1 && n == 3) set_write(1, 3, 16'd777);
      if (inj == 2 && n == 2) ready_force = 0;
      if (inj == 2 && n == 5) ready_force = 1;
      if (inj == 3 && n == 2) begin
        bus.start  = 1'b1;
        bus.length = 5'd3;
      end
      if (inj == 4 && n == 3) begin
        rst = 1'b1;
        #1;
        check("rst_ctrl", {bus.busy, bus.valid, bus.last, bus.done}, 0);
        check("rst_bias", bus.bias_out, 0);
        check("rst_data", bus.data_out, 0);
        sb_q.delete();
        #1;
        rst = 1'b0;
        aborted = 1;
      end
      if (!aborted) begin
        @(posedge clk); #1;
        n++;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
      end
    end
    if (!aborted) begin
      check("done_seen", bus.done, 1);
      if (inj == 3) begin
        bus.start  = 1'b1;
        bus.length = 5'd2;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hs_count", hs_n - hs0, len);
      check("sb_empty", sb_q.size(), 0);
      if (inj == 3) begin
        repeat (2) @(posedge clk);
        #1;
        check("no_restart", {bus.busy, bus.valid}, 0);
      end
    end
  endtask
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      pv       = 0;
      exp_done = 0;
    end else begin
      check("done", bus.done, exp_done);
      if (bus.valid) begin
        if (pv && !pr) begin
          check("hold_data", bus.data_out, pd);
          check("hold_bias", bus.bias_out, pb);
          check("hold_last", bus.last, pl);
        end
        if (bus.ready) begin
          hs_n++;
          if (sb_q.size() == 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL extra_handshake: got data %0h want none", bus.data_out);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("data[%0d]", e.idx), bus.data_out, e.data);
            check($sformatf("bias[%0d]", e.idx), bus.bias_out, e.bias);
            check($sformatf("last[%0d]", e.idx), bus.last, e.last);
          end
        end
      end else begin
        check("idle_data", bus.data_out, 0);
        check("idle_bias", bus.bias_out, 0);
        check("idle_last", bus.last, 0);
      end
      exp_done = bus.valid && bus.ready && bus.last;
      pv = bus.valid;
      pr = bus.ready;
      pl = bus.last;
      pd = bus.data_out;
      pb = bus.bias_out;
    end
  end
  initial begin
    int n;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.length = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {bus.busy, bus.valid, bus.last, bus.done}, 0);
    check("reset_data", {bus.bias_out, bus.data_out}, 0);
    rst = 1'b0;
    for (int k = 1; k <= CH; k++)
      for (int a = 0; a < D; a++) drive_write(k, a, 16'($urandom));
    drive_write(0, 0, 16'd29);
    drive_write(1, 0, -16'sd316);
    drive_write(1, 1, 16'sd267);
    drive_write(1, 2, -16'sd359);
    drive_write(1, 3, -16'sd297);
    run(4, 0, n);
    check("done_cycle_basic", n, 5);
    run(4, 2, n);
    check("done_cycle_stall", n, 8);
    bus.start = 1'b1; bus.length = 5'd0;
    @(posedge clk); #1;
    bus.length = 5'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bad_length_ignored", {bus.busy, bus.valid}, 0);
      @(posedge clk); #1;
    end
    run(4, 1, n);
    run(4, 0, n);
    run(10, 3, n);
    run(4, 4, n);
    @(posedge clk); #1;
    run(2, 0, n);
    rand_ready = 1;
    repeat (8) begin
      repeat (3) drive_write($urandom_range(0, 7), $urandom_range(0, 15), 16'($urandom));
      run($urandom_range(1, 10), 0, n);
    end
    rand_ready = 0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
